// File: rtl/game_fsm.sv
// Game state controller: start/restart, invulnerable HIT window with sprite blink, game over.
// Optional PAUSED state is built in when GAME_FSM_PAUSE_EN is defined.
module game_fsm #(
    parameter int HIT_CYCLES = 25000000,
    parameter int BLINK_DIV  = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic [2:0] i_Lives,
    output logic       o_Lives_Reset,
    output logic       o_Playing,
    output logic       o_Collision_Mask,
    output logic       o_Hit_Blink,
    output logic       o_Game_Over,
    output logic [2:0] o_State
);

    localparam int HIT_W = (HIT_CYCLES > 2) ? $clog2(HIT_CYCLES) : 1;
    localparam int DIV_W = $clog2(BLINK_DIV + 1);
    localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HIT_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAYING   = 3'd1,
        S_HIT       = 3'd2,
`ifdef GAME_FSM_PAUSE_EN
        S_GAME_OVER = 3'd3,
        S_PAUSED    = 3'd4
`else
        S_GAME_OVER = 3'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             start_q;
    logic [2:0]       lives_prev_q;
    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             blink_q, blink_d;
    logic             lives_reset_q, lives_reset_d;
    logic             playing_q, playing_d;
    logic             mask_q, mask_d;
    logic             game_over_q, game_over_d;
    logic             start_edge;
    logic             loss;

    assign start_edge = i_Start & ~start_q;
    assign loss       = (i_Lives < lives_prev_q);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q       <= S_IDLE;
            // Treat the button as already pressed so a held button cannot start a game on release.
            start_q       <= 1'b1;
            lives_prev_q  <= 3'd0;
            hit_cnt_q     <= '0;
            div_cnt_q     <= '0;
            blink_q       <= 1'b0;
            lives_reset_q <= 1'b0;
            playing_q     <= 1'b0;
            mask_q        <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= i_Start;
            lives_prev_q  <= i_Lives;
            hit_cnt_q     <= hit_cnt_d;
            div_cnt_q     <= div_cnt_d;
            blink_q       <= blink_d;
            lives_reset_q <= lives_reset_d;
            playing_q     <= playing_d;
            mask_q        <= mask_d;
            game_over_q   <= game_over_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hit_cnt_d     = '0;
        lives_reset_d = 1'b0;
        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    state_d       = S_PLAYING;
                    lives_reset_d = 1'b1;
                end
            end
            S_PLAYING: begin
                if (loss) begin
                    state_d = (i_Lives == 3'd0) ? S_GAME_OVER : S_HIT;
                end
`ifdef GAME_FSM_PAUSE_EN
                else if (start_edge) begin
                    state_d = S_PAUSED;
                end
`endif
            end
            S_HIT: begin
                // A fresh loss outranks expiry: either end the game or restart the window.
                if (loss) begin
                    state_d = (i_Lives == 3'd0) ? S_GAME_OVER : S_HIT;
                end else if (hit_cnt_q == HIT_LAST) begin
                    state_d = S_PLAYING;
                end else begin
                    hit_cnt_d = hit_cnt_q + 1'b1;
                end
            end
`ifdef GAME_FSM_PAUSE_EN
            S_PAUSED: begin
                if (start_edge) begin
                    state_d = S_PLAYING;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Blink divider runs only inside HIT; it is reset on entry, not on a window restart.
    always_comb begin
        div_cnt_d = '0;
        blink_d   = 1'b0;
        if (state_d == S_HIT) begin
            if (state_q != S_HIT) begin
                blink_d = 1'b1;
            end else if (div_cnt_q == DIV_LAST) begin
                blink_d = ~blink_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
                blink_d   = blink_q;
            end
        end
    end

    always_comb begin
        playing_d   = (state_d == S_PLAYING) || (state_d == S_HIT);
        mask_d      = (state_d == S_HIT);
        game_over_d = (state_d == S_GAME_OVER);
    end

    assign o_State          = state_q;
    assign o_Lives_Reset    = lives_reset_q;
    assign o_Playing        = playing_q;
    assign o_Collision_Mask = mask_q;
    assign o_Hit_Blink      = blink_q;
    assign o_Game_Over      = game_over_q;

endmodule

// File: tb/tb_game_fsm.sv
// Table-driven bench for game_fsm (HIT_CYCLES=8, BLINK_DIV=2) with an expected-result queue.
module tb_game_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] lives;
    logic       lives_reset, playing, mask, blink, game_over;
    logic [2:0] state;

    game_fsm #(.HIT_CYCLES(8), .BLINK_DIV(2)) dut (
        .i_Clk            (clk),
        .i_Reset          (rst),
        .i_Start          (start),
        .i_Lives          (lives),
        .o_Lives_Reset    (lives_reset),
        .o_Playing        (playing),
        .o_Collision_Mask (mask),
        .o_Hit_Blink      (blink),
        .o_Game_Over      (game_over),
        .o_State          (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       lr, pl, mk, bl, go;
        logic       bx;   // blink not checked
    } exp_t;

    typedef struct {
        logic       s;
        logic [2:0] l;
        exp_t       e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic s, input logic [2:0] l, input logic [2:0] st,
                                input logic lr, input logic pl, input logic mk,
                                input logic bl, input logic go, input logic bx);
        vec_t v;
        v.s = s; v.l = l;
        v.e.name = $sformatf("row%0d", tbl.size());
        v.e.st = st; v.e.lr = lr; v.e.pl = pl; v.e.mk = mk; v.e.bl = bl; v.e.go = go; v.e.bx = bx;
        tbl.push_back(v);
    endfunction

    task automatic compare_front();
        exp_t e;
        logic [6:0] got, want;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow got=empty want=entry");
        end else begin
            e = sb.pop_front();
            got  = {state, lives_reset, playing, mask, (e.bx ? 1'b0 : blink), game_over};
            want = {e.st, e.lr, e.pl, e.mk, (e.bx ? 1'b0 : e.bl), e.go};
            if (got !== want) begin
                errors++;
                $display("FAIL %s got st/lr/pl/mk/bl/go=%b want=%b", e.name, got, want);
            end else begin
                $display("ok   %s st=%0d lr=%b pl=%b mk=%b bl=%b go=%b", e.name,
                         state, lives_reset, playing, mask, blink, game_over);
            end
        end
    endtask

    task automatic apply(input logic s, input logic [2:0] l, input exp_t e);
        @(negedge clk);
        start = s;
        lives = l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic step(input string nm, input logic s, input logic [2:0] l, input logic [2:0] st,
                        input logic lr, input logic pl, input logic mk, input logic bl, input logic go);
        exp_t e;
        e.name = nm; e.st = st; e.lr = lr; e.pl = pl; e.mk = mk; e.bl = bl; e.go = go; e.bx = 1'b0;
        apply(s, l, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        //  s  l  st lr pl mk bl go bx
        add(0, 3, 0, 0, 0, 0, 0, 0, 0);   // idle, start_q leaves its reset value
        add(1, 3, 1, 1, 1, 0, 0, 0, 0);   // start edge -> PLAYING + lives reset
        add(1, 3, 1, 0, 1, 0, 0, 0, 0);   // pulse gone, button held
        add(0, 3, 1, 0, 1, 0, 0, 0, 0);
        add(0, 2, 2, 0, 1, 1, 1, 0, 0);   // loss -> HIT, blink 1,1,0,0,1,1,0,0
        add(0, 2, 2, 0, 1, 1, 1, 0, 0);
        add(0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(0, 2, 2, 0, 1, 1, 1, 0, 0);
        add(0, 2, 2, 0, 1, 1, 1, 0, 0);
        add(0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(0, 2, 1, 0, 1, 0, 0, 0, 0);   // exactly 8 HIT cycles then PLAYING
        add(0, 3, 1, 0, 1, 0, 0, 0, 0);   // increase is not a loss
        add(0, 2, 2, 0, 1, 1, 1, 0, 0);   // HIT index 0
        add(0, 2, 2, 0, 1, 1, 1, 0, 0);
        add(0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(0, 2, 2, 0, 1, 1, 1, 0, 0);   // HIT index 4
        for (int i = 0; i < 8; i++)        // loss at index 5 restarts: 8 more HIT cycles
            add(0, 1, 2, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 2, 1, 0, 1, 0, 0, 0, 0);
        add(0, 1, 2, 0, 1, 1, 1, 0, 0);
        add(0, 1, 2, 0, 1, 1, 1, 0, 0);
        add(0, 0, 3, 0, 0, 0, 0, 1, 0);   // last life lost inside HIT
        add(0, 0, 3, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 1, 1, 0, 0, 0, 0);   // restart from GAME_OVER
        add(0, 3, 1, 0, 1, 0, 0, 0, 0);   // lives reload 0->3, no HIT
        add(0, 3, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 3, 0, 0, 0, 0, 1, 0);   // last life lost in PLAYING
        add(0, 0, 3, 0, 0, 0, 0, 1, 0);
        add(1, 3, 1, 1, 1, 0, 0, 0, 0);
        add(1, 2, 2, 0, 1, 1, 1, 0, 0);   // enter HIT with start held high
        add(1, 2, 2, 0, 1, 1, 1, 0, 0);

        start = 1'b1;
        lives = 3'd3;
        rst   = 1'b1;
        #12;
        e.name = "reset_state"; e.st = 0; e.lr = 0; e.pl = 0; e.mk = 0; e.bl = 0; e.go = 0; e.bx = 0;
        sb.push_back(e);
        compare_front();
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;

        foreach (tbl[i]) apply(tbl[i].s, tbl[i].l, tbl[i].e);

        // Asynchronous reset mid-HIT while the button stays pressed.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        e.name = "async_reset_mid_hit";
        sb.push_back(e);
        compare_front();
        @(negedge clk);
        rst = 1'b0;
        step("held_after_reset_a", 1, 2, 0, 0, 0, 0, 0, 0);
        step("held_after_reset_b", 1, 2, 0, 0, 0, 0, 0, 0);
        step("released",           0, 2, 0, 0, 0, 0, 0, 0);
        step("new_edge",           1, 2, 1, 1, 1, 0, 0, 0);
        step("play_again",         0, 2, 1, 0, 1, 0, 0, 0);
`ifdef GAME_FSM_PAUSE_EN
        step("pause",              1, 2, 4, 0, 0, 0, 0, 0);
        step("pause_loss_ignored", 0, 1, 4, 0, 0, 0, 0, 0);
        step("pause_hold",         0, 1, 4, 0, 0, 0, 0, 0);
        step("resume",             1, 1, 1, 0, 1, 0, 0, 0);
        step("resume_no_hit",      0, 1, 1, 0, 1, 0, 0, 0);
`else
        step("start_ignored_play", 1, 2, 1, 0, 1, 0, 0, 0);
        step("play_steady",        0, 2, 1, 0, 1, 0, 0, 0);
        step("hit_again",          0, 1, 2, 0, 1, 1, 1, 0);
        step("start_ignored_hit",  1, 1, 2, 0, 1, 1, 1, 0);
        step("hit_blink_low",      0, 1, 2, 0, 1, 1, 0, 0);
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
